game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Top-level game FSM for the 16x16 flappy-bird playfield. Divides clk into game ticks and moves
//  the bird (gravity/flap), scrolls the pipe and draws new gap positions from an LFSR.
//  Tracks score and ends the game on pipe collision or floor hit.
//  Drives bird/pipe coordinates to the collision-check and display blocks; consumes their collision flag.
// PARAMETERS
//  TICK_DIV     25_000_000  clk cycles per game tick (>=2)
//  BIRD_X       12          fixed bird column, 0..15
//  GAP_SIZE     4           vertical gap rows; must match collision-check block
//  FLAP_HEIGHT  2           rows risen per flap
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-high reset
//  start      in   1  1-cycle pulse (debounced key): start game / return to idle
//  flap       in   1  1-cycle pulse (debounced key)
//  collision  in   1  combinational collision flag for current bird/pipe outputs
//  bird_x     out  4  constant BIRD_X
//  bird_y     out  4  bird row, 0 = top, 15 = floor
//  pipe_x     out  4  pipe column
//  gap_y      out  4  top row of gap, 0..12
//  score      out  8  pipes passed, saturates at 255
//  playing    out  1  high in PLAY
//  game_over  out  1  high in OVER
//  high_score out  8  best score (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): state=IDLE, bird_y=7, pipe_x=15, gap_y=6, score=0, flag/tick counter=0, lfsr=8'hA5.
//  States: IDLE -start-> PLAY (reload reset coordinates, score=0); PLAY -hit-> OVER; OVER -start-> IDLE.
//  hit = registered in the cycle collision==1 or bird_y==15 while in PLAY; OVER entered next cycle,
//   all coordinates frozen from then on.
//  Tick: counter counts 0..TICK_DIV-1 only in PLAY, held 0 otherwise; tick pulse on terminal count.
//  flap_pending: set by flap in PLAY, cleared on tick; flap and tick same cycle -> counts for that tick.
//  On tick: bird_y = flap_pending ? sat0(bird_y-FLAP_HEIGHT) : bird_y+1 (max 15).
//   pipe_x: 0 wraps to 15 and gap_y loads new value, else pipe_x-1.
//   score+1 (sat 255) when pipe_x moves from BIRD_X to BIRD_X-1 and no hit that cycle.
//  New gap: n=lfsr[3:0]; gap_y = (n>12) ? n-8 : n. LFSR 8-bit Fibonacci, taps 8,6,5,4, steps every clk
//   in all states (never all-zero).
//  start in PLAY ignored; flap in IDLE/OVER ignored; start+flap same cycle in IDLE -> start only.
//  Collision sampled every clk in PLAY, not only on ticks; a hit on a tick cycle suppresses that
//   tick's score increment but the coordinate update still lands.
//  Reset mid-game: immediate return to reset values; high_score also cleared.
// CONFIGURATION
//  HIGH_SCORE_EN defined: high_score register, updated to score on PLAY->OVER if score > high_score.
//  Not defined: no register; high_score tied to 8'd0.
// STRUCTURE
//  Package flappy_pkg: state_t enum {IDLE,PLAY,OVER}; GRID_MAX=4'd15; BIRD_Y_INIT=4'd7;
//   PIPE_X_INIT=4'd15; GAP_Y_INIT=4'd6; LFSR_SEED=8'hA5.
//  Sub-module tick_gen (TICK_DIV; clk, reset, en -> tick) holds the divider counter.
// TESTING  (TICK_DIV=4, defaults otherwise)
//  reset, no input 50 clks -> stays IDLE, bird_y=7, pipe_x=15, score=0, playing=0.
//  start; 4 ticks, no flap -> bird_y 7->11, pipe_x 15->11, tick every 4 clks.
//  PLAY bird_y=5, flap then tick -> bird_y=3; bird_y=1, flap -> bird_y=0 (saturate).
//  pipe_x=12, gap_y=10, bird_y=11 (in gap), tick -> pipe_x=11, score=1; bird_y=9 at pipe_x=12 with
//   collision=1 -> game_over next clk, coordinates frozen.
//  no flaps from bird_y=7 -> bird_y=15 after 8 ticks -> OVER; start -> IDLE; start -> PLAY, score=0.
//  HIGH_SCORE_EN: end games with score 3 then 1 -> high_score=3; without macro -> high_score=0.

Source files
------------

// File: rtl/flappy_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package : flappy_pkg                                                        |
// | Brief   : Shared state encoding, reset coordinates and LFSR/gap helpers     |
// |           for the 16x16 flappy-bird game sequencer.                         |
// | Rev     : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
package flappy_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   localparam logic [3:0] GRID_MAX    = 4'd15;
   localparam logic [3:0] BIRD_Y_INIT = 4'd7;
   localparam logic [3:0] PIPE_X_INIT = 4'd15;
   localparam logic [3:0] GAP_Y_INIT  = 4'd6;
   localparam logic [7:0] LFSR_SEED   = 8'hA5;

   // 8-bit Fibonacci LFSR, taps 8,6,5,4; a non-zero seed never reaches all-zero.
   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
   endfunction

   // Fold the low LFSR nibble into the legal gap range 0..gap_max.
   function automatic logic [3:0] gap_from_lfsr(input logic [7:0] cur,
                                                input logic [3:0] gap_max);
      logic [3:0] n;
      n = cur[3:0];
      return (n > gap_max) ? (n - 4'd8) : n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/game_sequencer_tick_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tick_gen                                                          |
// | Brief   : Game tick divider. Counts 0..TICK_DIV-1 while enabled, held at 0  |
// |           otherwise; tick is high on the terminal count.                    |
// | Rev     : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
module tick_gen #(
   parameter int TICK_DIV = 25_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_count;

   // Divider counter: wraps on terminal count, parked at zero when disabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_count <= '0;
      else if (!en || (r_count == TERM))
         r_count <= '0;
      else
         r_count <= r_count + 1'b1;
   end

   assign tick = en && (r_count == TERM);

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : game_sequencer                                                    |
// | Brief   : Flappy-bird game FSM: tick-driven bird/pipe motion, LFSR gap      |
// |           generation, score and end-of-game detection.                      |
// | Config  : define HIGH_SCORE_EN to keep a best-score register; otherwise     |
// |           high_score is tied to zero.                                       |
// | Rev     : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
module game_sequencer
   import flappy_pkg::*;
#(
   parameter int TICK_DIV    = 25_000_000,
   parameter int BIRD_X      = 12,
   parameter int GAP_SIZE    = 4,
   parameter int FLAP_HEIGHT = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       flap,
   input  logic       collision,
   output logic [3:0] bird_x,
   output logic [3:0] bird_y,
   output logic [3:0] pipe_x,
   output logic [3:0] gap_y,
   output logic [7:0] score,
   output logic       playing,
   output logic       game_over,
   output logic [7:0] high_score
);

   localparam logic [3:0] BIRD_X_C = 4'(BIRD_X);
   localparam logic [3:0] FLAP_H   = 4'(FLAP_HEIGHT);
   // Highest legal gap top row so the whole gap stays on the grid.
   localparam logic [3:0] GAP_MAX  = 4'(16 - GAP_SIZE);

   state_t     r_state, w_state_nxt;
   logic [3:0] r_bird_y, w_bird_y_nxt;
   logic [3:0] r_pipe_x, w_pipe_x_nxt;
   logic [3:0] r_gap_y, w_gap_y_nxt;
   logic [7:0] r_score, w_score_nxt;
   logic       r_flap_pending, w_flap_pending_nxt;
   logic [7:0] r_lfsr;
   logic       w_tick;
   logic       w_hit;
   logic       w_flap_now;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .en    (r_state == PLAY),
      .tick  (w_tick)
   );

   // State and game-coordinate registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= IDLE;
         r_bird_y       <= BIRD_Y_INIT;
         r_pipe_x       <= PIPE_X_INIT;
         r_gap_y        <= GAP_Y_INIT;
         r_score        <= 8'd0;
         r_flap_pending <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_bird_y       <= w_bird_y_nxt;
         r_pipe_x       <= w_pipe_x_nxt;
         r_gap_y        <= w_gap_y_nxt;
         r_score        <= w_score_nxt;
         r_flap_pending <= w_flap_pending_nxt;
      end
   end

   // Next-state and per-tick game update; coordinates only move in PLAY.
   always_comb begin
      w_state_nxt        = r_state;
      w_bird_y_nxt       = r_bird_y;
      w_pipe_x_nxt       = r_pipe_x;
      w_gap_y_nxt        = r_gap_y;
      w_score_nxt        = r_score;
      w_flap_pending_nxt = r_flap_pending;
      w_hit              = 1'b0;
      // A flap arriving on the tick cycle still applies to that tick.
      w_flap_now         = r_flap_pending | flap;

      unique case (r_state)
         IDLE: begin
            w_flap_pending_nxt = 1'b0;
            if (start) begin
               w_state_nxt  = PLAY;
               w_bird_y_nxt = BIRD_Y_INIT;
               w_pipe_x_nxt = PIPE_X_INIT;
               w_gap_y_nxt  = GAP_Y_INIT;
               w_score_nxt  = 8'd0;
            end
         end
         PLAY: begin
            w_hit = collision | (r_bird_y == GRID_MAX);
            if (w_tick) begin
               w_flap_pending_nxt = 1'b0;
               if (w_flap_now)
                  w_bird_y_nxt = (r_bird_y < FLAP_H) ? 4'd0 : (r_bird_y - FLAP_H);
               else if (r_bird_y != GRID_MAX)
                  w_bird_y_nxt = r_bird_y + 4'd1;
               if (r_pipe_x == 4'd0) begin
                  w_pipe_x_nxt = GRID_MAX;
                  w_gap_y_nxt  = gap_from_lfsr(r_lfsr, GAP_MAX);
               end else begin
                  w_pipe_x_nxt = r_pipe_x - 4'd1;
               end
               // Pipe is passed when it leaves the bird column; a hit voids it.
               if ((r_pipe_x == BIRD_X_C) && !w_hit && (r_score != 8'hFF))
                  w_score_nxt = r_score + 8'd1;
            end else if (flap) begin
               w_flap_pending_nxt = 1'b1;
            end
            if (w_hit)
               w_state_nxt = OVER;
         end
         OVER: begin
            w_flap_pending_nxt = 1'b0;
            if (start)
               w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Free-running gap generator, stepped every clock in every state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_lfsr <= LFSR_SEED;
      else
         r_lfsr <= lfsr_next(r_lfsr);
   end

`ifdef HIGH_SCORE_EN
   logic [7:0] r_high_score;

   // Best score, captured when a game ends with a new record.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_high_score <= 8'd0;
      else if ((r_state == PLAY) && w_hit && (r_score > r_high_score))
         r_high_score <= r_score;
   end

   assign high_score = r_high_score;
`else
   assign high_score = 8'd0;
`endif

   assign bird_x    = BIRD_X_C;
   assign bird_y    = r_bird_y;
   assign pipe_x    = r_pipe_x;
   assign gap_y     = r_gap_y;
   assign score     = r_score;
   assign playing   = (r_state == PLAY);
   assign game_over = (r_state == OVER);

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_game_sequencer                                                 |
// | Brief   : Randomized scoreboard bench for game_sequencer against a          |
// |           rule-level game model (TICK_DIV=4).                               |
// | Rev     : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
module tb_game_sequencer;

   localparam int DIV = 4;
   localparam int BX  = 12;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       flap;
   logic       collision;
   logic [3:0] bird_x, bird_y, pipe_x, gap_y;
   logic [7:0] score, high_score;
   logic       playing, game_over;

   game_sequencer #(
      .TICK_DIV    (DIV),
      .BIRD_X      (BX),
      .GAP_SIZE    (4),
      .FLAP_HEIGHT (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .flap       (flap),
      .collision  (collision),
      .bird_x     (bird_x),
      .bird_y     (bird_y),
      .pipe_x     (pipe_x),
      .gap_y      (gap_y),
      .score      (score),
      .playing    (playing),
      .game_over  (game_over),
      .high_score (high_score)
   );

   always #5 clk = ~clk;

   typedef struct {
      int bird_y;
      int pipe_x;
      int gap_y;
      int score;
      int hs;
      int playing;
      int over;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference game model: mode 0 = idle, 1 = playing, 2 = over.
   int m_mode, m_bird, m_pipe, m_gap, m_score, m_hs, m_cnt, m_lfsr;
   bit m_fp;

   task automatic model_reset();
      m_mode = 0; m_bird = 7; m_pipe = 15; m_gap = 6; m_score = 0;
      m_hs = 0; m_cnt = 0; m_lfsr = 'hA5; m_fp = 1'b0;
   endtask

   function automatic exp_t model_view();
      exp_t e;
      e.bird_y  = m_bird;
      e.pipe_x  = m_pipe;
      e.gap_y   = m_gap;
      e.score   = m_score;
`ifdef HIGH_SCORE_EN
      e.hs      = m_hs;
`else
      e.hs      = 0;
`endif
      e.playing = (m_mode == 1) ? 1 : 0;
      e.over    = (m_mode == 2) ? 1 : 0;
      return e;
   endfunction

   // One clock of the game rules with the inputs that were present at the edge.
   task automatic model_step(input bit st, input bit fl, input bit col);
      bit tick, hit;
      int old_mode, n;
      old_mode = m_mode;
      tick     = (m_mode == 1) && (m_cnt == DIV - 1);
      if (m_mode == 0) begin
         if (st) begin
            m_mode = 1; m_bird = 7; m_pipe = 15; m_gap = 6; m_score = 0; m_fp = 1'b0;
         end
      end else if (m_mode == 1) begin
         hit = col || (m_bird == 15);
         if (tick) begin
            if (m_fp || fl) m_bird = (m_bird >= 2) ? m_bird - 2 : 0;
            else if (m_bird < 15) m_bird = m_bird + 1;
            m_fp = 1'b0;
            if (m_pipe == BX && !hit && m_score < 255) m_score = m_score + 1;
            if (m_pipe == 0) begin
               m_pipe = 15;
               n      = m_lfsr % 16;
               m_gap  = (n > 12) ? n - 8 : n;
            end else begin
               m_pipe = m_pipe - 1;
            end
         end else if (fl) begin
            m_fp = 1'b1;
         end
         if (hit) begin
            m_mode = 2;
            if (m_score > m_hs) m_hs = m_score;
         end
      end else if (st) begin
         m_mode = 0;
      end
      m_cnt  = (old_mode == 1 && !tick) ? m_cnt + 1 : 0;
      m_lfsr = ((m_lfsr << 1) & 255) | ($countones(m_lfsr & 'hB8) % 2);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input int req);
      total++;
      if (act !== 32'(req)) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every negedge the DUT presents a settled state; compare with the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("bird_x",     bird_x,     BX);
            chk("bird_y",     bird_y,     e.bird_y);
            chk("pipe_x",     pipe_x,     e.pipe_x);
            chk("gap_y",      gap_y,      e.gap_y);
            chk("score",      score,      e.score);
            chk("playing",    playing,    e.playing);
            chk("game_over",  game_over,  e.over);
            chk("high_score", high_score, e.hs);
         end
      end
   end

   // Stimulus: model advances at each posedge, new inputs chosen 1 ns later.
   initial begin
      bit smart;
      exp_t dummy;
      reset = 1'b1; start = 1'b0; flap = 1'b0; collision = 1'b0;
      smart = 1'b1;
      model_reset();
      #1 q.push_back(model_view());
      @(posedge clk);
      #1 reset = 1'b0;

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge clk);
         model_step(start, flap, collision);
         q.push_back(model_view());
         #1;
         if (cyc % 1313 == 1000) begin
            // Asynchronous reset in the middle of a cycle.
            reset = 1'b1;
            model_reset();
            dummy = q.pop_back();
            q.push_back(model_view());
            #2 reset = 1'b0;
         end
         if (cyc < 50) begin
            start = 1'b0;
            flap  = 1'b0;
         end else begin
            start = ($urandom_range(0, 59) == 0);
            if (m_mode != 1 && $urandom_range(0, 7) == 0) begin
               start = 1'b1;
               smart = ($urandom_range(0, 3) != 0);
            end
            if (m_mode == 1 && smart)
               flap = (m_bird > m_gap + 2) && ($urandom_range(0, 2) == 0);
            else
               flap = ($urandom_range(0, 5) == 0);
         end
         collision = ((m_pipe == BX) && (m_bird < m_gap || m_bird >= m_gap + 4)) ||
                     ((m_mode == 1) && ($urandom_range(0, 299) == 0));
      end

      start = 1'b0; flap = 1'b0; collision = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d expected 0 pending entries", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
